fetch_stage: RTL and testbench

//   IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection and the IF/ID pipeline register.

---
 rtl/pipeline_defs.sv | 10 +
 rtl/if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline constants: address width, reset PC, bubble instruction and instruction width.
package pipeline_defs;

  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  // sll $0,$0,0 doubles as the pipeline bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// Generic "hold or bubble" stage register: holds instr/pc_plus4/valid, with a write enable and a flush input.
module if_id_reg
  import pipeline_defs::INSTR_W;
#(
  parameter int                   ADDR_W    = pipeline_defs::ADDR_W,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = pipeline_defs::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_en,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_plus4_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               valid
);

  // A disabled write holds all three fields, even when a flush is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (write_en) begin
      pc_plus4 <= pc_plus4_in;
      if (flush) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else begin
        instr <= instr_in;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC select and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
  import pipeline_defs::INSTR_W;
#(
  parameter int                 ADDR_W    = pipeline_defs::ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = pipeline_defs::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipeline_defs::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               if_id_write,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus4,
  output logic               if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flush_count
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_next;
  logic              redirect;

  assign imem_addr = pc;
  assign pc_plus4  = pc + ADDR_W'(4);
  // A redirect seen while stalled is dropped; the ID instruction re-resolves next cycle.
  assign redirect  = pc_write & (jump | branch_taken);

  always_comb begin
    pc_next = pc_plus4;
    if (jump)
      pc_next = jump_target & ALIGN_MASK;
    else if (branch_taken)
      pc_next = branch_target & ALIGN_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (pc_write)
      pc <= pc_next;
  end

  if_id_reg #(
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .write_en    (if_id_write),
    .flush       (redirect),
    .instr_in    (imem_rdata),
    .pc_plus4_in (pc_plus4),
    .instr       (if_id_instr),
    .pc_plus4    (if_id_pc_plus4),
    .valid       (if_id_valid)
  );

`ifdef FETCH_PERF_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (!pc_write && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect && perf_flush_count != 32'hFFFF_FFFF)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; also checks the perf counters when FETCH_PERF_EN is defined.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory model: a known ADDI at 0x0, an address-tagged word elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h2008_0005;
    return 32'hAC00_0000 | {16'h0000, addr[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic pw, input logic iw,
                       input logic bt, input logic [31:0] btgt,
                       input logic j, input logic [31:0] jtgt);
    rst = r; pc_write = pw; if_id_write = iw;
    branch_taken = bt; branch_target = btgt;
    jump = j; jump_target = jtgt;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_p4, input logic e_valid);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".imem_addr"}, imem_addr, e_pc);
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".pc_plus4"}, if_id_pc_plus4, e_p4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
  endtask

  task automatic check_perf(input string tag, input logic [31:0] e_stall, input logic [31:0] e_flush);
`ifdef FETCH_PERF_EN
    check({tag, ".stall"}, perf_stall_cycles, e_stall);
    check({tag, ".flush"}, perf_flush_count, e_flush);
`else
    vectors += 0;
    if (e_stall === 32'hx || e_flush === 32'hx) $display("[TB] %s perf unused", tag);
`endif
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    step();
    step();
    check_ifid("reset", 32'h0, NOP, 32'h0, 1'b0);
    check_perf("reset", 32'd0, 32'd0);

    // Free running from 0x0
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("run1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    step();
    check_ifid("run2", 32'h8, mem_word(32'h4), 32'h8, 1'b1);
    step();
    check_ifid("run3", 32'hC, mem_word(32'h8), 32'hC, 1'b1);
    step();
    check_ifid("run4", 32'h10, mem_word(32'hC), 32'h10, 1'b1);

    // Two stall cycles at 0x10; the second carries a branch that must be ignored
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("stall1", 32'h10, mem_word(32'hC), 32'h10, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    check_ifid("stall2_br", 32'h10, mem_word(32'hC), 32'h10, 1'b1);
    check_perf("stall2_br", 32'd2, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("unstall", 32'h14, mem_word(32'h10), 32'h14, 1'b1);

    // Jump to 0x20, then taken branch to unaligned 0x43
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20);
    step();
    check_ifid("jmp20", 32'h20, NOP, 32'h18, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h43, 1'b0, 32'h0);
    step();
    check_ifid("br43", 32'h40, NOP, 32'h24, 1'b0);
    check_perf("br43", 32'd2, 32'd2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("after_br", 32'h44, mem_word(32'h40), 32'h44, 1'b1);

    // Jump and branch together: jump wins
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
    step();
    check_ifid("jmp_vs_br", 32'h100, NOP, 32'h48, 1'b0);
    check_perf("jmp_vs_br", 32'd2, 32'd3);

    // Unaligned jump to the top of memory, then wrap to 0
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    step();
    check_ifid("jmp_top", 32'hFFFF_FFFC, NOP, 32'h104, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("wrap", 32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Enables disagree: each register obeys its own
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_ifid("pc_only", 32'h4, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    step();
    check_ifid("ifid_only", 32'h4, mem_word(32'h4), 32'h8, 1'b1);
    check_perf("ifid_only", 32'd3, 32'd4);

    // Reset during a stall with a pending redirect
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h600);
    step();
    check_ifid("rst_stall", 32'h0, NOP, 32'h0, 1'b0);
    check_perf("rst_stall", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
